// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised accumulator CPU: opcodes, FSM states
// and the opcode field position within an instruction word.
package cpu_pkg;

    localparam int unsigned OPC_W = 3;

    localparam logic [OPC_W-1:0] OP_NOP = 3'd0;
    localparam logic [OPC_W-1:0] OP_LDA = 3'd1;
    localparam logic [OPC_W-1:0] OP_STA = 3'd2;
    localparam logic [OPC_W-1:0] OP_ADD = 3'd3;
    localparam logic [OPC_W-1:0] OP_SUB = 3'd4;
    localparam logic [OPC_W-1:0] OP_JMP = 3'd5;
    localparam logic [OPC_W-1:0] OP_JZ  = 3'd6;
    localparam logic [OPC_W-1:0] OP_HLT = 3'd7;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ARG   = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    // Opcode occupies the top OPC_W bits of a DATA_W-wide word.
    function automatic int unsigned opc_lsb(input int unsigned data_w);
        return data_w - OPC_W;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational add/subtract for the accumulator with carry/borrow and zero flag.
module cpu_alu #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    output logic [DATA_W-1:0] res_c,
    output logic              carry_c,
    output logic              zero_c
);

    logic [DATA_W:0] sum;

    // Extra top bit is the carry on add and the borrow (b > a) on subtract.
    always_comb begin
        if (sub_i) begin
            sum = {1'b0, a_i} - {1'b0, b_i};
        end else begin
            sum = {1'b0, a_i} + {1'b0, b_i};
        end
    end

    assign res_c   = sum[DATA_W-1:0];
    assign carry_c = sum[DATA_W];
    assign zero_c  = (sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/cpu_param.sv
// Multicycle accumulator CPU with generic widths and a ready-handshake port to a
// single shared instruction/data memory; runs until HLT, leaves halt only by reset.
module cpu_param
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] to_memory,
    output logic              write,
    output logic              mem_req,
    input  logic [DATA_W-1:0] from_memory,
    input  logic              mem_ready,
    output logic              halted,
    output logic [DATA_W-1:0] acc,
    output logic              zero,
    output logic              carry
);

    localparam int unsigned OPC_LSB = opc_lsb(DATA_W);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [OPC_W-1:0]    ir_q, ir_d;
    logic [ADDR_W-1:0]   arg_q, arg_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                zero_q, zero_d;
    logic                carry_q, carry_d;
    logic                halted_q, halted_d;

    logic [ADDR_W-1:0]   address_c;
    logic                mem_req_c;
    logic                write_c;
    logic                xfer_c;
    logic [OPC_W-1:0]    word_op_c;
    logic [ADDR_W-1:0]   word_addr_c;
    logic [DATA_W-1:0]   alu_res_c;
    logic                alu_carry_c;
    logic                alu_zero_c;

    assign xfer_c      = mem_req_c && mem_ready;
    assign word_op_c   = from_memory[OPC_LSB +: OPC_W];
    assign word_addr_c = from_memory[ADDR_W-1:0];

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a_i     (acc_q),
        .b_i     (from_memory),
        .sub_i   (ir_q == OP_SUB),
        .res_c   (alu_res_c),
        .carry_c (alu_carry_c),
        .zero_c  (alu_zero_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= OP_NOP;
            arg_q    <= '0;
            acc_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            arg_q    <= arg_d;
            acc_q    <= acc_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            halted_q <= halted_d;
        end
    end

    // Next state and datapath updates; nothing moves until the access completes.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        arg_d    = arg_q;
        acc_d    = acc_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        halted_d = halted_q;
        case (state_q)
            S_FETCH: begin
                if (xfer_c) begin
                    ir_d = word_op_c;
                    pc_d = pc_q + ADDR_W'(1);
                    case (word_op_c)
                        OP_NOP:  state_d = S_FETCH;
                        OP_HLT: begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                        end
                        default: state_d = S_ARG;
                    endcase
                end
            end
            S_ARG: begin
                if (xfer_c) begin
                    arg_d = word_addr_c;
                    pc_d  = pc_q + ADDR_W'(1);
                    case (ir_q)
                        OP_JMP: begin
                            pc_d    = word_addr_c;
                            state_d = S_FETCH;
                        end
                        OP_JZ: begin
                            if (zero_q) begin
                                pc_d = word_addr_c;
                            end
                            state_d = S_FETCH;
                        end
                        default: state_d = S_EXEC;
                    endcase
                end
            end
            S_EXEC: begin
                if (xfer_c) begin
                    state_d = S_FETCH;
                    case (ir_q)
                        OP_LDA: begin
                            acc_d  = from_memory;
                            zero_d = (from_memory == '0);
                        end
                        OP_ADD, OP_SUB: begin
                            acc_d   = alu_res_c;
                            carry_d = alu_carry_c;
                            zero_d  = alu_zero_c;
                        end
                        default: ;
                    endcase
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Memory port decode; request and write are forced low while reset is held.
    always_comb begin
        mem_req_c = 1'b0;
        write_c   = 1'b0;
        address_c = pc_q;
        case (state_q)
            S_FETCH, S_ARG: mem_req_c = 1'b1;
            S_EXEC: begin
                mem_req_c = 1'b1;
                address_c = arg_q;
                write_c   = (ir_q == OP_STA);
            end
            default: ;
        endcase
        if (!reset) begin
            mem_req_c = 1'b0;
            write_c   = 1'b0;
        end
    end

    assign address   = address_c;
    assign mem_req   = mem_req_c;
    assign write     = write_c;
    assign to_memory = acc_q;
    assign acc       = acc_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_param.sv
// Directed bench for cpu_param with a wait-state memory model.
module tb_cpu_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] address;
    logic [7:0] to_memory;
    logic       write;
    logic       mem_req;
    logic [7:0] from_memory;
    logic       mem_ready;
    logic       halted;
    logic [7:0] acc;
    logic       zero;
    logic       carry;

    logic [7:0]  mem [256];
    logic        clr;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [7:0]  ld_data;
    int unsigned waits;
    int unsigned wcnt = 0;

    int errors = 0;
    int checks = 0;

    logic [7:0] pv_addr, pv_dat;
    logic       pv_req, pv_rdy, pv_wr;

    always #5 clk = ~clk;

    cpu_param #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .to_memory   (to_memory),
        .write       (write),
        .mem_req     (mem_req),
        .from_memory (from_memory),
        .mem_ready   (mem_ready),
        .halted      (halted),
        .acc         (acc),
        .zero        (zero),
        .carry       (carry)
    );

    assign from_memory = mem[address];
    assign mem_ready   = mem_req && (wcnt == waits);

    // Memory model: clear, program load, or one access every waits+1 cycles.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            wcnt <= 0;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_req && mem_ready) begin
            if (write) mem[address] <= to_memory;
            wcnt <= 0;
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_test(input int unsigned w);
        reset = 1'b0;
        waits = w;
        clr   = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic prog1();
        poke(8'h00, 8'h20); poke(8'h01, 8'h10);
        poke(8'h02, 8'h60); poke(8'h03, 8'h11);
        poke(8'h04, 8'h40); poke(8'h05, 8'h12);
        poke(8'h06, 8'hE0);
        poke(8'h10, 8'h05); poke(8'h11, 8'h03);
    endtask

    initial begin
        reset = 1'b0; clr = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; waits = 0;

        // Program 1, no wait states
        begin_test(0);
        prog1();
        check("rst_address", address, 8'h00);
        check("rst_to_memory", to_memory, 8'h00);
        check("rst_write", 8'(write), 8'd0);
        check("rst_mem_req", 8'(mem_req), 8'd0);
        check("rst_halted", 8'(halted), 8'd0);
        check("rst_acc", acc, 8'h00);
        check("rst_zero", 8'(zero), 8'd0);
        check("rst_carry", 8'(carry), 8'd0);
        release_reset();
        check("t1_first_req", 8'(mem_req), 8'd1);
        step(9);
        check("t1_halted_c9", 8'(halted), 8'd0);
        step(1);
        check("t1_halted_c10", 8'(halted), 8'd1);
        check("t1_acc", acc, 8'h08);
        check("t1_zero", 8'(zero), 8'd0);
        check("t1_carry", 8'(carry), 8'd0);
        check("t1_mem12", mem[8'h12], 8'h08);
        check("t1_halt_req", 8'(mem_req), 8'd0);
        step(2);
        check("t1_halt_hold", 8'(halted), 8'd1);
        check("t1_halt_req2", 8'(mem_req), 8'd0);

        // ADD overflow to zero, JZ taken
        begin_test(0);
        poke(8'h00, 8'h20); poke(8'h01, 8'h20);
        poke(8'h02, 8'h60); poke(8'h03, 8'h21);
        poke(8'h04, 8'hC0); poke(8'h05, 8'h30);
        poke(8'h20, 8'hFF); poke(8'h21, 8'h01);
        release_reset();
        step(3);
        check("t2_lda_acc", acc, 8'hFF);
        check("t2_lda_zero", 8'(zero), 8'd0);
        step(3);
        check("t2_add_acc", acc, 8'h00);
        check("t2_add_carry", 8'(carry), 8'd1);
        check("t2_add_zero", 8'(zero), 8'd1);
        step(2);
        check("t2_jz_addr", address, 8'h30);
        check("t2_jz_req", 8'(mem_req), 8'd1);
        check("t2_jz_write", 8'(write), 8'd0);

        // SUB with borrow, JZ not taken, LDA keeps carry
        begin_test(0);
        poke(8'h00, 8'h20); poke(8'h01, 8'h20);
        poke(8'h02, 8'h80); poke(8'h03, 8'h21);
        poke(8'h04, 8'hC0); poke(8'h05, 8'h30);
        poke(8'h06, 8'h20); poke(8'h07, 8'h22);
        poke(8'h20, 8'h03); poke(8'h21, 8'h05);
        release_reset();
        step(6);
        check("t3_sub_acc", acc, 8'hFE);
        check("t3_sub_carry", 8'(carry), 8'd1);
        check("t3_sub_zero", 8'(zero), 8'd0);
        step(2);
        check("t3_jz_fall", address, 8'h06);
        step(3);
        check("t3_lda0_acc", acc, 8'h00);
        check("t3_lda0_zero", 8'(zero), 8'd1);
        check("t3_lda0_carry", 8'(carry), 8'd1);

        // Program 1 with two wait cycles per access
        begin_test(2);
        prog1();
        release_reset();
        for (int c = 1; c <= 30; c++) begin
            pv_addr = address; pv_dat = to_memory;
            pv_req = mem_req; pv_rdy = mem_ready; pv_wr = write;
            step(1);
            if (pv_req && !pv_rdy) begin
                check("t4_hold_addr", address, pv_addr);
                check("t4_hold_req", 8'(mem_req), 8'(pv_req));
                check("t4_hold_write", 8'(write), 8'(pv_wr));
                check("t4_hold_data", to_memory, pv_dat);
            end
            if (c == 29) check("t4_halted_c29", 8'(halted), 8'd0);
        end
        check("t4_halted_c30", 8'(halted), 8'd1);
        check("t4_acc", acc, 8'h08);
        check("t4_mem12", mem[8'h12], 8'h08);

        // Reset asserted in the middle of the STA write
        begin_test(0);
        prog1();
        poke(8'h12, 8'h55);
        release_reset();
        step(8);
        check("t5_sta_write", 8'(write), 8'd1);
        check("t5_sta_req", 8'(mem_req), 8'd1);
        check("t5_sta_addr", address, 8'h12);
        check("t5_sta_data", to_memory, 8'h08);
        reset = 1'b0;
        #1;
        check("t5_rst_write", 8'(write), 8'd0);
        check("t5_rst_req", 8'(mem_req), 8'd0);
        check("t5_rst_acc", acc, 8'h00);
        step(1);
        check("t5_target", mem[8'h12], 8'h55);
        release_reset();
        check("t5_fetch_addr", address, 8'h00);
        check("t5_fetch_req", 8'(mem_req), 8'd1);

        // JMP to top of memory and pc wrap
        begin_test(0);
        poke(8'h00, 8'hA0); poke(8'h01, 8'hFE);
        release_reset();
        step(2);
        check("t6_addr_fe", address, 8'hFE);
        check("t6_req_fe", 8'(mem_req), 8'd1);
        step(1);
        check("t6_addr_ff", address, 8'hFF);
        step(1);
        check("t6_addr_wrap", address, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
